// File: rtl/lc3b_rr_mem_arbiter.sv
// Line-granularity arbiter: N upstream cache channels share one downstream memory port.
// One transaction is in flight at a time; round-robin or fixed-priority winner selection.
module lc3b_rr_mem_arbiter #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          up_read,
    input  logic [N_CH-1:0]          up_write,
    input  logic [N_CH*ADDR_W-1:0]   up_address,
    input  logic [N_CH*LINE_W-1:0]   up_wdata,
    output logic [LINE_W-1:0]        up_rdata,
    output logic [N_CH-1:0]          up_resp,
    output logic                     dn_read,
    output logic                     dn_write,
    output logic [ADDR_W-1:0]        dn_address,
    output logic [LINE_W-1:0]        dn_wdata,
    input  logic [LINE_W-1:0]        dn_rdata,
    input  logic                     dn_resp
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic [N_CH-1:0]   req;
    logic              any_req;
    logic [CH_W-1:0]   scan_base;
    logic [CH_W-1:0]   win;
    logic              found;
    int unsigned       scan_idx;

    logic [ADDR_W-1:0] ch_addr  [N_CH];
    logic [LINE_W-1:0] ch_wdata [N_CH];

    assign req     = up_read | up_write;
    assign any_req = |req;

    for (genvar c = 0; c < N_CH; c++) begin : g_unpack
        assign ch_addr[c]  = up_address[c*ADDR_W +: ADDR_W];
        assign ch_wdata[c] = up_wdata[c*LINE_W +: LINE_W];
    end

    // Scan from the base index upward, wrapping; fixed priority scans from channel 0.
    always_comb begin
        scan_base = (RR_MODE != 0) ? rr_ptr_q : '0;
        win       = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            scan_idx = 32'(scan_base) + i;
            if (scan_idx >= N_CH) begin
                scan_idx = scan_idx - N_CH;
            end
            if (!found && req[CH_W'(scan_idx)]) begin
                found = 1'b1;
                win   = CH_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = win;
                    // A channel asserting both read and write is treated as a write.
                    op_wr_d = up_write[win];
                    addr_d  = ch_addr[win];
                    wdata_d = ch_wdata[win];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (dn_resp) begin
                    rdata_d = op_wr_q ? '0 : dn_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only, so an async reset clears them at once.
    always_comb begin
        dn_read    = 1'b0;
        dn_write   = 1'b0;
        dn_address = '0;
        dn_wdata   = '0;
        up_resp    = '0;
        up_rdata   = '0;
        if (state_q == StIssue) begin
            dn_read    = ~op_wr_q;
            dn_write   = op_wr_q;
            dn_address = addr_q;
            dn_wdata   = wdata_q;
        end
        if (state_q == StResp) begin
            up_resp[grant_q] = 1'b1;
            up_rdata         = rdata_q;
        end
    end

endmodule

// File: tb/tb_lc3b_rr_mem_arbiter.sv
// Directed bench: 2-channel RR, 4-channel RR and 4-channel fixed-priority instances.
module tb_lc3b_rr_mem_arbiter;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    // 2-channel round-robin instance
    logic [1:0]   d2_up_read, d2_up_write, d2_up_resp;
    logic [31:0]  d2_up_address;
    logic [255:0] d2_up_wdata;
    logic [127:0] d2_up_rdata, d2_dn_wdata, d2_dn_rdata;
    logic         d2_dn_read, d2_dn_write, d2_dn_resp;
    logic [15:0]  d2_dn_address;

    // 4-channel round-robin instance
    logic [3:0]   d4_up_read, d4_up_write, d4_up_resp;
    logic [63:0]  d4_up_address;
    logic [511:0] d4_up_wdata;
    logic [127:0] d4_up_rdata, d4_dn_wdata, d4_dn_rdata;
    logic         d4_dn_read, d4_dn_write, d4_dn_resp;
    logic [15:0]  d4_dn_address;

    // 4-channel fixed-priority instance
    logic [3:0]   fp_up_read, fp_up_write, fp_up_resp;
    logic [63:0]  fp_up_address;
    logic [511:0] fp_up_wdata;
    logic [127:0] fp_up_rdata, fp_dn_wdata, fp_dn_rdata;
    logic         fp_dn_read, fp_dn_write, fp_dn_resp;
    logic [15:0]  fp_dn_address;

    lc3b_rr_mem_arbiter #(.N_CH(2), .ADDR_W(16), .LINE_W(128), .RR_MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .up_read(d2_up_read), .up_write(d2_up_write), .up_address(d2_up_address),
        .up_wdata(d2_up_wdata), .up_rdata(d2_up_rdata), .up_resp(d2_up_resp),
        .dn_read(d2_dn_read), .dn_write(d2_dn_write), .dn_address(d2_dn_address),
        .dn_wdata(d2_dn_wdata), .dn_rdata(d2_dn_rdata), .dn_resp(d2_dn_resp)
    );

    lc3b_rr_mem_arbiter #(.N_CH(4), .ADDR_W(16), .LINE_W(128), .RR_MODE(1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .up_read(d4_up_read), .up_write(d4_up_write), .up_address(d4_up_address),
        .up_wdata(d4_up_wdata), .up_rdata(d4_up_rdata), .up_resp(d4_up_resp),
        .dn_read(d4_dn_read), .dn_write(d4_dn_write), .dn_address(d4_dn_address),
        .dn_wdata(d4_dn_wdata), .dn_rdata(d4_dn_rdata), .dn_resp(d4_dn_resp)
    );

    lc3b_rr_mem_arbiter #(.N_CH(4), .ADDR_W(16), .LINE_W(128), .RR_MODE(0)) dutfp (
        .clk(clk), .rst_n(rst_n),
        .up_read(fp_up_read), .up_write(fp_up_write), .up_address(fp_up_address),
        .up_wdata(fp_up_wdata), .up_rdata(fp_up_rdata), .up_resp(fp_up_resp),
        .dn_read(fp_dn_read), .dn_write(fp_dn_write), .dn_address(fp_dn_address),
        .dn_wdata(fp_dn_wdata), .dn_rdata(fp_dn_rdata), .dn_resp(fp_dn_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({d2_dn_read, d2_dn_write, d2_up_resp} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000", {d2_dn_read, d2_dn_write, d2_up_resp});
        end
        tests_run++;
        if (d2_dn_address !== 16'h0 || d2_dn_wdata !== 128'h0 || d2_up_rdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0",
                     d2_dn_address, d2_dn_wdata, d2_up_rdata);
        end
        tests_run++;
        if (d4_up_resp !== 4'b0 || fp_up_resp !== 4'b0 || d4_dn_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wide: d4 resp %b fp resp %b d4 rd %b expected 0",
                     d4_up_resp, fp_up_resp, d4_dn_read);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (d2_dn_read !== 1'b0 || d2_dn_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: rd %b wr %b expected 0 0", d2_dn_read, d2_dn_write);
        end
    endtask

    task automatic test_single_read();
        d2_up_address[16 +: 16] = 16'h1230;
        d2_up_read = 2'b10;
        @(negedge clk);
        tests_run++;
        if (d2_dn_read !== 1'b1 || d2_dn_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_issue: rd %b wr %b expected 1 0", d2_dn_read, d2_dn_write);
        end
        tests_run++;
        if (d2_dn_address !== 16'h1230) begin
            tests_failed++;
            $display("FAIL read_addr: got %h expected 1230", d2_dn_address);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (d2_up_resp !== 2'b00 || d2_dn_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_wait: resp %b rd %b expected 00 1", d2_up_resp, d2_dn_read);
        end
        d2_dn_rdata = {16{8'hA5}};
        d2_dn_resp  = 1'b1;
        @(negedge clk);
        d2_dn_resp  = 1'b0;
        d2_dn_rdata = '0;
        tests_run++;
        if (d2_up_resp !== 2'b10) begin
            tests_failed++;
            $display("FAIL read_resp: got %b expected 10", d2_up_resp);
        end
        tests_run++;
        if (d2_up_rdata !== {16{8'hA5}}) begin
            tests_failed++;
            $display("FAIL read_data: got %h expected a5..a5", d2_up_rdata);
        end
        tests_run++;
        if (d2_dn_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_dn_drop: got %b expected 0", d2_dn_read);
        end
        d2_up_read = 2'b00;
        @(negedge clk);
        tests_run++;
        if (d2_up_resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_pulse: got %b expected 00", d2_up_resp);
        end
    endtask

    task automatic test_single_write();
        d2_up_address[0 +: 16]  = 16'h2000;
        d2_up_wdata[0 +: 128]   = 128'h0123456789ABCDEF0123456789ABCDEF;
        d2_up_write = 2'b01;
        @(negedge clk);
        tests_run++;
        if (d2_dn_write !== 1'b1 || d2_dn_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_issue: wr %b rd %b expected 1 0", d2_dn_write, d2_dn_read);
        end
        tests_run++;
        if (d2_dn_address !== 16'h2000 || d2_dn_wdata !== 128'h0123456789ABCDEF0123456789ABCDEF)
        begin
            tests_failed++;
            $display("FAIL write_payload: addr %h wdata %h expected 2000 0123..cdef",
                     d2_dn_address, d2_dn_wdata);
        end
        d2_dn_rdata = 128'hDEAD_BEEF;
        d2_dn_resp  = 1'b1;
        @(negedge clk);
        d2_dn_resp  = 1'b0;
        d2_dn_rdata = '0;
        tests_run++;
        if (d2_up_resp !== 2'b01 || d2_up_rdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL write_resp: resp %b rdata %h expected 01 0", d2_up_resp, d2_up_rdata);
        end
        d2_up_write = 2'b00;
        @(negedge clk);
    endtask

    // Pointer is 1 here (last grant ch0); reset must bring it back to 0.
    task automatic test_reset_mid_issue();
        d2_up_address[16 +: 16] = 16'h4444;
        d2_up_read = 2'b10;
        @(negedge clk);
        tests_run++;
        if (d2_dn_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_issue: got %b expected 1", d2_dn_read);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (d2_dn_read !== 1'b0 || d2_dn_address !== 16'h0 || d2_up_resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_async: rd %b addr %h resp %b expected 0 0000 00",
                     d2_dn_read, d2_dn_address, d2_up_resp);
        end
        d2_up_read = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d2_up_address = {16'h0BBB, 16'h0AAA};
        d2_up_read = 2'b11;
        @(negedge clk);
        tests_run++;
        if (d2_dn_address !== 16'h0AAA || d2_dn_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_ptr_grant: addr %h rd %b expected 0aaa 1", d2_dn_address, d2_dn_read);
        end
        d2_dn_resp = 1'b1;
        @(negedge clk);
        d2_dn_resp = 1'b0;
        tests_run++;
        if (d2_up_resp !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_ptr_resp: got %b expected 01", d2_up_resp);
        end
        d2_up_read = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_rr_fairness();
        int          ch;
        int          cnt;
        logic [3:0]  exp_resp;
        logic [15:0] exp_addr;
        for (int c = 0; c < 4; c++) d4_up_address[c*16 +: 16] = 16'(16'h1000 + c);
        d4_up_read = 4'hF;
        for (int n = 0; n < 6; n++) begin
            ch       = n % 4;
            exp_resp = 4'b0001 << ch;
            exp_addr = 16'(16'h1000 + ch);
            cnt = 0;
            while (d4_dn_read !== 1'b1 && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            tests_run++;
            if (d4_dn_address !== exp_addr || d4_dn_read !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: addr %h rd %b expected %h 1",
                         n, d4_dn_address, d4_dn_read, exp_addr);
            end
            d4_dn_resp = 1'b1;
            @(negedge clk);
            d4_dn_resp = 1'b0;
            tests_run++;
            if (d4_up_resp !== exp_resp) begin
                tests_failed++;
                $display("FAIL rr_resp_%0d: got %b expected %b", n, d4_up_resp, exp_resp);
            end
            if (n == 5) d4_up_read = 4'h0;
            @(negedge clk);
        end
    endtask

    task automatic test_fixed_priority();
        int          ch;
        int          cnt;
        logic [3:0]  exp_resp;
        logic [15:0] exp_addr;
        fp_up_address[0 +: 16]  = 16'h00C0;
        fp_up_address[32 +: 16] = 16'h02C2;
        fp_up_read = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            ch       = (n < 3) ? 0 : 2;
            exp_resp = 4'b0001 << ch;
            exp_addr = (ch == 0) ? 16'h00C0 : 16'h02C2;
            cnt = 0;
            while (fp_dn_read !== 1'b1 && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            tests_run++;
            if (fp_dn_address !== exp_addr || fp_dn_read !== 1'b1) begin
                tests_failed++;
                $display("FAIL fp_grant_%0d: addr %h rd %b expected %h 1",
                         n, fp_dn_address, fp_dn_read, exp_addr);
            end
            fp_dn_resp = 1'b1;
            @(negedge clk);
            fp_dn_resp = 1'b0;
            tests_run++;
            if (fp_up_resp !== exp_resp) begin
                tests_failed++;
                $display("FAIL fp_resp_%0d: got %b expected %b", n, fp_up_resp, exp_resp);
            end
            if (n == 2) fp_up_read[0] = 1'b0;
            if (n == 3) fp_up_read = 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_stability();
        d2_up_address[0 +: 16] = 16'h3000;
        d2_up_read = 2'b01;
        @(negedge clk);
        // Upstream address changes and the request drops while the op is in flight.
        d2_up_address[0 +: 16] = 16'hFFFF;
        d2_up_read = 2'b00;
        @(negedge clk);
        tests_run++;
        if (d2_dn_address !== 16'h3000 || d2_dn_read !== 1'b1) begin
            tests_failed++;
            $display("FAIL stable_addr: addr %h rd %b expected 3000 1", d2_dn_address, d2_dn_read);
        end
        d2_dn_rdata = {16{8'h5A}};
        d2_dn_resp  = 1'b1;
        @(negedge clk);
        tests_run++;
        if (d2_up_resp !== 2'b01 || d2_up_rdata !== {16{8'h5A}}) begin
            tests_failed++;
            $display("FAIL dropped_req_resp: resp %b rdata %h expected 01 5a..5a",
                     d2_up_resp, d2_up_rdata);
        end
        // dn_resp held through RESP and an idle cycle must have no effect.
        @(negedge clk);
        @(negedge clk);
        d2_dn_resp = 1'b0;
        tests_run++;
        if (d2_up_resp !== 2'b00 || d2_dn_read !== 1'b0 || d2_dn_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_dn_resp: resp %b rd %b wr %b expected 00 0 0",
                     d2_up_resp, d2_dn_read, d2_dn_write);
        end
        d2_up_address[16 +: 16] = 16'h5550;
        d2_up_wdata[128 +: 128] = {4{32'hCAFEF00D}};
        d2_up_read  = 2'b10;
        d2_up_write = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (d2_dn_write !== 1'b1 || d2_dn_read !== 1'b0) begin
                tests_failed++;
                $display("FAIL rw_is_write_%0d: wr %b rd %b expected 1 0",
                         k, d2_dn_write, d2_dn_read);
            end
        end
        tests_run++;
        if (d2_dn_wdata !== {4{32'hCAFEF00D}} || d2_dn_address !== 16'h5550) begin
            tests_failed++;
            $display("FAIL rw_payload: wdata %h addr %h expected cafef00d.. 5550",
                     d2_dn_wdata, d2_dn_address);
        end
        d2_dn_rdata = {16{8'h77}};
        d2_dn_resp  = 1'b1;
        @(negedge clk);
        d2_dn_resp  = 1'b0;
        tests_run++;
        if (d2_up_resp !== 2'b10 || d2_up_rdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL rw_resp: resp %b rdata %h expected 10 0", d2_up_resp, d2_up_rdata);
        end
        d2_up_read  = 2'b00;
        d2_up_write = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        d2_up_read = '0; d2_up_write = '0; d2_up_address = '0; d2_up_wdata = '0;
        d2_dn_rdata = '0; d2_dn_resp = 1'b0;
        d4_up_read = '0; d4_up_write = '0; d4_up_address = '0; d4_up_wdata = '0;
        d4_dn_rdata = '0; d4_dn_resp = 1'b0;
        fp_up_read = '0; fp_up_write = '0; fp_up_address = '0; fp_up_wdata = '0;
        fp_dn_rdata = '0; fp_dn_resp = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_reset_mid_issue();
        test_rr_fairness();
        test_fixed_priority();
        test_stability();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
